inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Responder side of the instruction-fetch interface. Accepts the fetch address `pc_i` and enable `ce_i` driven by the program counter.
- Reads the 16-bit instruction from external asynchronous SRAM over a multi-cycle access.
- Raises `stallreq_o` toward the stall controller until the instruction for the current address is valid.
- Sits between the PC stage and the IF/ID pipeline register.

Parameters:
- WAIT_CYCLES, 1, extra SRAM wait cycles per access (0..15).
- NOP_INST, 16'h0800, instruction word presented while no valid fetch is held.
- ADDR_HI, 2'b00, upper two bits of the 18-bit SRAM address (instruction bank select).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- pc_i  input  16  requested instruction address.
- ce_i  input  1  fetch enable; 0 = PC held in reset, no fetch.
- inst_o  output  16  fetched instruction to the IF/ID register.
- inst_valid_o  output  1  inst_o holds memory data for cur_addr.
- stallreq_o  output  1  pipeline stall request, combinational.
- ram_addr_o  output  18  SRAM address, registered.
- ram_data_i  input  16  SRAM read data.
- ram_ce_n_o  output  1  SRAM chip enable, active low.
- ram_oe_n_o  output  1  SRAM output enable, active low.
- ram_we_n_o  output  1  SRAM write enable, tied 1; block never writes.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE; inst_o = NOP_INST; inst_valid_o = 0.
  - cur_addr = 0; cnt = 0.
  - ram_addr_o = 0; ram_ce_n_o = 1; ram_oe_n_o = 1.
- Reset dominates every other event in the same cycle, including mid-access; an abandoned access leaves no valid data.
- hit = inst_valid_o && (cur_addr == pc_i). stallreq_o = ce_i && !hit. stallreq_o is 0 whenever ce_i = 0.
- States: IDLE, ACCESS (4-bit down-counter cnt).
- IDLE:
  - ce_i = 0: outputs hold; nothing starts.
  - ce_i = 1 and hit: nothing starts; inst_o / inst_valid_o hold.
  - ce_i = 1 and miss, at the edge:
    - cur_addr <= pc_i; ram_addr_o <= {ADDR_HI, pc_i}; ram_ce_n_o <= 0; ram_oe_n_o <= 0.
    - cnt <= WAIT_CYCLES; inst_valid_o <= 0; inst_o <= NOP_INST; state -> ACCESS.
- ACCESS:
  - cnt != 0: cnt <= cnt - 1.
  - cnt == 0:
    - inst_o <= ram_data_i; inst_valid_o <= 1.
    - ram_ce_n_o <= 1; ram_oe_n_o <= 1; state -> IDLE.
  - ce_i falls to 0 during ACCESS: abort at that edge. SRAM controls deasserted, inst_valid_o = 0, state -> IDLE; no data latched.
  - pc_i changes during ACCESS (should not occur while stalled, but is legal): the access completes for the old cur_addr. hit then evaluates 0 for the new pc_i, stallreq_o stays 1, and the next IDLE cycle starts a new access.
- Latency, miss to hit: WAIT_CYCLES + 2 rising edges. stallreq_o is high for exactly WAIT_CYCLES + 2 cycles per missed address when pc_i is held.
- Back-to-back fetches: at least one IDLE cycle between accesses; no pipelined overlap.
- ram_addr_o holds its last value outside ACCESS.

Optional Feature:
- Macro: FETCH_BUF_EN.
- Defined: one-entry buffer (buf_addr, buf_inst, buf_valid).
  - Reset clears buf_valid.
  - On every access completion, the previous {cur_addr, inst_o} is copied into the buffer if inst_valid_o was 1.
  - In IDLE with ce_i = 1, miss, and buf_valid && buf_addr == pc_i: no SRAM access.
    - At that edge, swap buffer and current entries: inst_o <= buf_inst; cur_addr <= pc_i; inst_valid_o <= 1.
    - Stall is 1 cycle instead of WAIT_CYCLES + 2.
  - ce_i = 0 abort also clears buf_valid.
- Undefined: no buffer registers; every miss goes to SRAM.

Test Plan:
- Reset: rst=1 for 2 cycles, ce_i=0 -> inst_o=16'h0800, inst_valid_o=0, ram_ce_n_o=1, ram_oe_n_o=1, stallreq_o=0.
- Single fetch, WAIT_CYCLES=1: ce_i=1, pc_i=16'h0000 held, SRAM[0]=16'h4801 -> ram_addr_o=18'h00000 with ram_oe_n_o=0 for 2 cycles. stallreq_o=1 for 3 cycles, then inst_o=16'h4801, inst_valid_o=1, stallreq_o=0.
- Sequential stream: pc_i advances 0x0000 -> 0x0001 only when stallreq_o=0 -> each address costs 3 stall cycles; inst_o sequence equals SRAM contents in order.
- Abort: ce_i dropped to 0 one cycle into ACCESS -> next cycle ram_oe_n_o=1, inst_valid_o=0, stallreq_o=0. Re-enable at 0x0005 -> fresh full-latency access.
- WAIT_CYCLES=0 with ADDR_HI=2'b01, pc_i=16'h1234 -> ram_addr_o=18'h11234; stall exactly 2 cycles.
- FETCH_BUF_EN: fetch 0x0010 then 0x0011, then pc_i back to 0x0010 -> no SRAM strobe; inst_o = SRAM[0x0010] after 1 stall cycle. Without the macro, the same stimulus gives a 3-cycle stall with an SRAM access.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch responder: reads one 16-bit word from asynchronous SRAM per missed PC
// and stalls the pipeline until it is valid. Define FETCH_BUF_EN to add a one-entry fetch buffer.
module inst_fetch_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] NOP_INST    = 16'h0800,
  parameter logic [1:0]  ADDR_HI     = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_i,
  input  logic        ce_i,
  output logic [15:0] inst_o,
  output logic        inst_valid_o,
  output logic        stallreq_o,
  output logic [17:0] ram_addr_o,
  input  logic [15:0] ram_data_i,
  output logic        ram_ce_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] cur_addr;
  logic        hit;
  logic        buf_hit;

`ifdef FETCH_BUF_EN
  logic [15:0] buf_addr;
  logic [15:0] buf_inst;
  logic        buf_valid;

  assign buf_hit = buf_valid && (buf_addr == pc_i);
`else
  assign buf_hit = 1'b0;
`endif

  assign hit        = inst_valid_o && (cur_addr == pc_i);
  assign stallreq_o = ce_i && !hit;
  assign ram_we_n_o = 1'b1;

  // NOTE: all state below is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cur_addr     <= 16'h0000;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      ram_addr_o   <= 18'h00000;
      ram_ce_n_o   <= 1'b1;
      ram_oe_n_o   <= 1'b1;
`ifdef FETCH_BUF_EN
      buf_addr     <= 16'h0000;
      buf_inst     <= NOP_INST;
      buf_valid    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ce_i && !hit) begin
            if (buf_hit) begin
`ifdef FETCH_BUF_EN
              // Buffer hit: swap the buffered entry with the current one, no SRAM cycle.
              inst_o       <= buf_inst;
              cur_addr     <= pc_i;
              inst_valid_o <= 1'b1;
              buf_addr     <= cur_addr;
              buf_inst     <= inst_o;
              buf_valid    <= inst_valid_o;
`endif
            end else begin
`ifdef FETCH_BUF_EN
              // The outgoing entry is saved as the access starts; an abort or reset
              // clears it, so this is equivalent to saving it on completion.
              buf_addr     <= cur_addr;
              buf_inst     <= inst_o;
              buf_valid    <= inst_valid_o;
`endif
              cur_addr     <= pc_i;
              ram_addr_o   <= {ADDR_HI, pc_i};
              ram_ce_n_o   <= 1'b0;
              ram_oe_n_o   <= 1'b0;
              cnt          <= WAIT_INIT;
              inst_valid_o <= 1'b0;
              inst_o       <= NOP_INST;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!ce_i) begin
            // PC went back to reset: drop the access and latch nothing.
            ram_ce_n_o   <= 1'b1;
            ram_oe_n_o   <= 1'b1;
            inst_valid_o <= 1'b0;
            state        <= IDLE;
`ifdef FETCH_BUF_EN
            buf_valid    <= 1'b0;
`endif
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            inst_o       <= ram_data_i;
            inst_valid_o <= 1'b1;
            ram_ce_n_o   <= 1'b1;
            ram_oe_n_o   <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: two instances (WAIT_CYCLES=1/ADDR_HI=0 and
// WAIT_CYCLES=0/ADDR_HI=1), each with a behavioural asynchronous SRAM.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, pc2;
  logic        ce, ce2;
  logic [15:0] inst, inst2;
  logic        valid, valid2;
  logic        stall, stall2;
  logic [17:0] ram_addr, ram_addr2;
  logic [15:0] ram_data, ram_data2;
  logic        ram_ce_n, ram_ce_n2;
  logic        ram_oe_n, ram_oe_n2;
  logic        ram_we_n, ram_we_n2;

  int vectors = 0;
  int errors  = 0;
  int oe_cycles = 0;
  int n;

  logic [15:0] mem [0:63];

  always #5 clk = ~clk;

  // SRAM drives data only while both chip and output enables are low.
  assign ram_data  = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[5:0]] : 16'hFFFF;
  assign ram_data2 = (!ram_ce_n2 && !ram_oe_n2) ? (ram_addr2[15:0] ^ 16'h5A5A) : 16'hFFFF;

  always @(negedge clk) if (!ram_oe_n) oe_cycles++;

  inst_fetch_ctrl #(.WAIT_CYCLES(1), .NOP_INST(16'h0800), .ADDR_HI(2'b00)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce),
    .inst_o(inst), .inst_valid_o(valid), .stallreq_o(stall),
    .ram_addr_o(ram_addr), .ram_data_i(ram_data),
    .ram_ce_n_o(ram_ce_n), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n)
  );

  inst_fetch_ctrl #(.WAIT_CYCLES(0), .NOP_INST(16'h0800), .ADDR_HI(2'b01)) dut2 (
    .clk(clk), .rst(rst), .pc_i(pc2), .ce_i(ce2),
    .inst_o(inst2), .inst_valid_o(valid2), .stallreq_o(stall2),
    .ram_addr_o(ram_addr2), .ram_data_i(ram_data2),
    .ram_ce_n_o(ram_ce_n2), .ram_oe_n_o(ram_oe_n2), .ram_we_n_o(ram_we_n2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with stall high on dut; bounded so a stuck stall cannot hang the run.
  task automatic wait_hit(output int cycles);
    cycles = 0;
    while (stall === 1'b1 && cycles < 50) begin
      tick();
      #1;
      cycles++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h4801; mem[1]  = 16'h4802; mem[2]  = 16'h4803;
    mem[3]  = 16'h4804; mem[5]  = 16'h1105; mem[6]  = 16'h4806;
    mem[7]  = 16'h4807; mem[16] = 16'h2210; mem[17] = 16'h2211;

    rst = 1'b1; ce = 1'b0; pc = 16'h0000; ce2 = 1'b0; pc2 = 16'h0000;
    tick(); tick(); #1;
    check("rst_inst",   inst,     16'h0800);
    check("rst_valid",  valid,    1'b0);
    check("rst_ce_n",   ram_ce_n, 1'b1);
    check("rst_oe_n",   ram_oe_n, 1'b1);
    check("rst_stall",  stall,    1'b0);
    check("rst_addr",   ram_addr, 18'h00000);
    check("we_n_tied",  ram_we_n, 1'b1);

    // Single fetch of address 0: 3 stall cycles, OE low for 2.
    rst = 1'b0; ce = 1'b1; pc = 16'h0000; #1;
    check("f0_stall_c0", stall, 1'b1);
    tick(); #1;
    check("f0_addr",     ram_addr, 18'h00000);
    check("f0_oe_c1",    ram_oe_n, 1'b0);
    check("f0_ce_c1",    ram_ce_n, 1'b0);
    check("f0_stall_c1", stall,    1'b1);
    tick(); #1;
    check("f0_oe_c2",    ram_oe_n, 1'b0);
    check("f0_stall_c2", stall,    1'b1);
    tick(); #1;
    check("f0_stall_c3", stall,    1'b0);
    check("f0_inst",     inst,     16'h4801);
    check("f0_valid",    valid,    1'b1);
    check("f0_oe_done",  ram_oe_n, 1'b1);

    // Sequential stream.
    pc = 16'h0001; #1; wait_hit(n);
    check("seq1_stall", n, 3);
    check("seq1_inst", inst, 16'h4802);
    pc = 16'h0002; #1; wait_hit(n);
    check("seq2_stall", n, 3);
    check("seq2_inst", inst, 16'h4803);

    // Abort one cycle into ACCESS.
    pc = 16'h0003; #1;
    tick();
    ce = 1'b0; #1;
    check("abort_stall_ce0", stall, 1'b0);
    tick(); #1;
    check("abort_oe_n",  ram_oe_n, 1'b1);
    check("abort_ce_n",  ram_ce_n, 1'b1);
    check("abort_valid", valid,    1'b0);
    check("abort_stall", stall,    1'b0);
    check("abort_inst",  inst,     16'h0800);
    ce = 1'b1; pc = 16'h0005; #1; wait_hit(n);
    check("reen_stall", n, 3);
    check("reen_inst",  inst, 16'h1105);

    // pc changes mid-access: old access completes, then new one starts.
    pc = 16'h0006; #1;
    tick();
    pc = 16'h0007;
    tick(); tick(); #1;
    check("pcchg_inst",  inst,  16'h4806);
    check("pcchg_valid", valid, 1'b1);
    check("pcchg_stall", stall, 1'b1);
    wait_hit(n);
    check("pcchg_new_stall", n, 3);
    check("pcchg_new_inst",  inst, 16'h4807);

    // Revisit the previous address: buffer hit when the buffer is built in.
    pc = 16'h0010; #1; wait_hit(n);
    check("b10_inst", inst, 16'h2210);
    pc = 16'h0011; #1; wait_hit(n);
    check("b11_inst", inst, 16'h2211);
    oe_cycles = 0;
    pc = 16'h0010; #1; wait_hit(n);
`ifdef FETCH_BUF_EN
    check("rev_stall", n, 1);
    check("rev_oe_cycles", oe_cycles, 0);
`else
    check("rev_stall", n, 3);
    check("rev_oe_cycles", oe_cycles, 2);
`endif
    check("rev_inst", inst, 16'h2210);

    // Zero wait states with ADDR_HI=01 on the second instance.
    ce2 = 1'b1; pc2 = 16'h1234; #1;
    check("w0_stall_c0", stall2, 1'b1);
    tick(); #1;
    check("w0_addr",     ram_addr2, 18'h11234);
    check("w0_oe",       ram_oe_n2, 1'b0);
    check("w0_stall_c1", stall2,    1'b1);
    tick(); #1;
    check("w0_stall_c2", stall2, 1'b0);
    check("w0_inst",     inst2,  16'h486E);
    check("w0_valid",    valid2, 1'b1);

    // Synchronous reset mid-access leaves no valid data.
    pc2 = 16'h0042; #1;
    tick();
    rst = 1'b1;
    tick(); #1;
    check("rst_mid_valid", valid2,    1'b0);
    check("rst_mid_oe",    ram_oe_n2, 1'b1);
    check("rst_mid_inst",  inst2,     16'h0800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
